// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Define ARB_STATS_EN to add grant/conflict statistics counters.
module mem_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]       stat_if_gnt,
   output logic [31:0]       stat_dm_gnt,
   output logic [31:0]       stat_conflict
`endif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_RDWAIT = 2'd2;
   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  lat_q, lat_d;
   logic [7:0]        starve_q, starve_d;
   logic              if_gnt_q, dm_gnt_q, if_rvalid_q, dm_rvalid_q, own_dm_q;
   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;

   logic capture, arb, if_el, dm_el, starved, dm_win, if_win, win, conflict;

   always_comb begin
      capture  = (state_q == S_RDWAIT) && (lat_q == '0);
      // A write frees the port at the end of its issue cycle; a read at its capture edge.
      arb      = (state_q == S_IDLE) || ((state_q == S_ISSUE) && mem_we_q) || capture;
      if_el    = if_req && !if_gnt_q;
      dm_el    = dm_req && !dm_gnt_q;
      starved  = (STARVE_MAX != 0) && (starve_q >= 8'(STARVE_MAX));
      dm_win   = arb && dm_el && !(if_el && starved);
      if_win   = arb && if_el && !dm_win;
      win      = dm_win || if_win;
      conflict = arb && if_el && dm_el;
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      case (state_q)
         S_IDLE:   if (win) state_d = S_ISSUE;
         S_ISSUE:  if (mem_we_q) begin
                      state_d = win ? S_ISSUE : S_IDLE;
                   end else begin
                      state_d = S_RDWAIT;
                      lat_d   = CNT_W'(RD_LAT - 1);
                   end
         S_RDWAIT: if (capture) state_d = win ? S_ISSUE : S_IDLE;
                   else         lat_d   = lat_q - CNT_W'(1);
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (!if_req || if_win)
         starve_d = 8'd0;
      else if (if_el && dm_win && (starve_q != 8'hFF))
         starve_d = starve_q + 8'd1;
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lat_q       <= '0;
         starve_q    <= '0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         own_dm_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         if_gnt_q    <= if_win;
         dm_gnt_q    <= dm_win;
         mem_en_q    <= win;
         mem_we_q    <= dm_win && dm_we;
         mem_addr_q  <= dm_win ? dm_addr : (if_win ? if_addr : '0);
         mem_wdata_q <= (dm_win && dm_we) ? dm_wdata : '0;
         if (win) own_dm_q <= dm_win;
         if_rvalid_q <= capture && !own_dm_q;
         dm_rvalid_q <= capture && own_dm_q;
         if (capture && !own_dm_q) if_rdata_q <= mem_rdata;
         if (capture && own_dm_q)  dm_rdata_q <= mem_rdata;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign dm_gnt    = dm_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign dm_rvalid = dm_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = ((state_q == S_ISSUE) && !mem_we_q) || (state_q == S_RDWAIT);

`ifdef ARB_STATS_EN
   logic [31:0] st_if_q, st_dm_q, st_cf_q;

   always_ff @(posedge clk1) begin
      if (rst) begin
         st_if_q <= '0;
         st_dm_q <= '0;
         st_cf_q <= '0;
      end else begin
         if (if_win)   st_if_q <= st_if_q + 32'd1;
         if (dm_win)   st_dm_q <= st_dm_q + 32'd1;
         if (conflict) st_cf_q <= st_cf_q + 32'd1;
      end
   end

   assign stat_if_gnt   = st_if_q;
   assign stat_dm_gnt   = st_dm_q;
   assign stat_conflict = st_cf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle-latency memory model (STARVE_MAX=3).
module tb_mem_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk1 = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [AW-1:0] mem_addr;
`ifdef ARB_STATS_EN
   logic [31:0]   stat_if_gnt, stat_dm_gnt, stat_conflict;
`endif

   logic [DW-1:0] mem [0:1023];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   int total = 0;
   int passed = 0;

   always #5 clk1 = ~clk1;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(3)) dut (
      .clk1(clk1), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
      , .stat_if_gnt(stat_if_gnt), .stat_dm_gnt(stat_dm_gnt), .stat_conflict(stat_conflict)
`endif
   );

   // Synchronous memory: read data valid the cycle after the mem_en cycle.
   always @(posedge clk1) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   task automatic tick;
      @(posedge clk1);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      total++; if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy} !== 7'b0)
         $display("FAIL reset_ctrl got %b want 0", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy}); else passed++;
      total++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0)
         $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata}); else passed++;
      total++; if (dut.starve_q !== 8'd0) $display("FAIL reset_starve got %0d want 0", dut.starve_q); else passed++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch;
      if_req = 1'b1; if_addr = 10'd5;
      tick();
      if_req = 1'b0;
      total++; if ({if_gnt, dm_gnt, mem_en, mem_we, busy} !== 5'b10101)
         $display("FAIL fetch_gnt got %b want 10101", {if_gnt, dm_gnt, mem_en, mem_we, busy}); else passed++;
      total++; if (mem_addr !== 10'd5) $display("FAIL fetch_addr got %0d want 5", mem_addr); else passed++;
      tick();
      total++; if ({if_gnt, if_rvalid, mem_en, busy} !== 4'b0001)
         $display("FAIL fetch_wait got %b want 0001", {if_gnt, if_rvalid, mem_en, busy}); else passed++;
      tick();
      total++; if ({if_rvalid, busy} !== 2'b10) $display("FAIL fetch_rvalid got %b want 10", {if_rvalid, busy}); else passed++;
      total++; if (if_rdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata got %h want deadbeef", if_rdata); else passed++;
      tick();
      total++; if (if_rvalid !== 1'b0) $display("FAIL fetch_rvalid_pulse got %b want 0", if_rvalid); else passed++;
      total++; if (if_rdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata_hold got %h want deadbeef", if_rdata); else passed++;
      tick();
   endtask

   task automatic test_priority;
      if_req = 1'b1; if_addr = 10'd3;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd7; dm_wdata = 32'h12;
      tick();
      dm_req = 1'b0;
      total++; if ({dm_gnt, if_gnt, mem_en, mem_we} !== 4'b1011)
         $display("FAIL prio_dm_first got %b want 1011", {dm_gnt, if_gnt, mem_en, mem_we}); else passed++;
      total++; if ({mem_addr, mem_wdata} !== {10'd7, 32'h12})
         $display("FAIL prio_wr_bus got %h want 7/12", {mem_addr, mem_wdata}); else passed++;
      total++; if (dut.starve_q !== 8'd1) $display("FAIL prio_starve1 got %0d want 1", dut.starve_q); else passed++;
      tick();
      if_req = 1'b0;
      total++; if ({dm_gnt, if_gnt, mem_en, mem_we} !== 4'b0110)
         $display("FAIL prio_if_next got %b want 0110", {dm_gnt, if_gnt, mem_en, mem_we}); else passed++;
      total++; if ({mem_addr, mem_wdata} !== {10'd3, 32'h0})
         $display("FAIL prio_rd_bus got %h want 3/0", {mem_addr, mem_wdata}); else passed++;
      total++; if (dut.starve_q !== 8'd0) $display("FAIL prio_starve0 got %0d want 0", dut.starve_q); else passed++;
      total++; if (mem[7] !== 32'h12) $display("FAIL prio_mem7 got %h want 12", mem[7]); else passed++;
      tick(); tick();
      total++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hA5A50003})
         $display("FAIL prio_if_data got %b/%h want 1/a5a50003", if_rvalid, if_rdata); else passed++;
      tick();
   endtask

   task automatic test_starve;
      logic [10:0] e_dmg, e_ifg, e_dmv, e_ifv;
      e_dmg = 11'b001_0001_0101;
      e_ifg = 11'b000_0100_0000;
      e_dmv = 11'b100_0101_0100;
      e_ifv = 11'b001_0000_0000;
      if_req = 1'b1; if_addr = 10'd3;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd9;
      for (int k = 1; k <= 11; k++) begin
         tick();
         total++; if ({dm_gnt, if_gnt, dm_rvalid, if_rvalid} !== {e_dmg[k-1], e_ifg[k-1], e_dmv[k-1], e_ifv[k-1]})
            $display("FAIL starve_cyc%0d got %b want %b", k, {dm_gnt, if_gnt, dm_rvalid, if_rvalid},
                     {e_dmg[k-1], e_ifg[k-1], e_dmv[k-1], e_ifv[k-1]}); else passed++;
         if (e_dmv[k-1]) begin
            total++; if (dm_rdata !== 32'h00000999) $display("FAIL starve_dm_data%0d got %h want 999", k, dm_rdata); else passed++;
         end
         if (e_ifv[k-1]) begin
            total++; if (if_rdata !== 32'hA5A50003) $display("FAIL starve_if_data got %h want a5a50003", if_rdata); else passed++;
         end
         if (k == 7) if_req = 1'b0;
         if (k == 9) dm_req = 1'b0;
      end
      tick();
   endtask

   task automatic test_reset_inflight;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd9;
      tick();
      dm_req = 1'b0;
      total++; if (dm_gnt !== 1'b1) $display("FAIL rstfl_gnt got %b want 1", dm_gnt); else passed++;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy} !== 7'b0)
         $display("FAIL rstfl_ctrl got %b want 0", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy}); else passed++;
      total++; if ({mem_addr, if_rdata, dm_rdata} !== '0)
         $display("FAIL rstfl_data got %h want 0", {mem_addr, if_rdata, dm_rdata}); else passed++;
      tick(); tick();
      total++; if ({dm_rvalid, busy} !== 2'b00) $display("FAIL rstfl_dropped got %b want 00", {dm_rvalid, busy}); else passed++;
      if_req = 1'b1; if_addr = 10'd5;
      tick();
      if_req = 1'b0;
      total++; if (if_gnt !== 1'b1) $display("FAIL rstfl_if_gnt got %b want 1", if_gnt); else passed++;
      tick(); tick();
      total++; if ({if_rvalid, if_rdata, dm_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0})
         $display("FAIL rstfl_if_data got %b/%h/%b want 1/deadbeef/0", if_rvalid, if_rdata, dm_rvalid); else passed++;
      tick();
   endtask

   task automatic test_dm_during_fetch;
      if_req = 1'b1; if_addr = 10'd5;
      tick();
      if_req = 1'b0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd9;
      total++; if ({if_gnt, dm_gnt} !== 2'b10) $display("FAIL dmf_if_gnt got %b want 10", {if_gnt, dm_gnt}); else passed++;
      tick();
      total++; if ({dm_gnt, busy} !== 2'b01) $display("FAIL dmf_blocked got %b want 01", {dm_gnt, busy}); else passed++;
      tick();
      dm_req = 1'b0;
      total++; if ({if_rvalid, dm_gnt, mem_addr} !== {1'b1, 1'b1, 10'd9})
         $display("FAIL dmf_gnt_in_rvalid got %b/%b/%0d want 1/1/9", if_rvalid, dm_gnt, mem_addr); else passed++;
      tick();
      total++; if (dm_rvalid !== 1'b0) $display("FAIL dmf_early got %b want 0", dm_rvalid); else passed++;
      tick();
      total++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h00000999})
         $display("FAIL dmf_data got %b/%h want 1/999", dm_rvalid, dm_rdata); else passed++;
      tick();
   endtask

`ifdef ARB_STATS_EN
   task automatic test_stats;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if ({stat_if_gnt, stat_dm_gnt, stat_conflict} !== '0)
         $display("FAIL stats_reset got %h want 0", {stat_if_gnt, stat_dm_gnt, stat_conflict}); else passed++;
      tick();
      test_priority();
      test_starve();
      total++; if (stat_if_gnt !== 32'd2) $display("FAIL stats_if got %0d want 2", stat_if_gnt); else passed++;
      total++; if (stat_dm_gnt !== 32'd5) $display("FAIL stats_dm got %0d want 5", stat_dm_gnt); else passed++;
      total++; if (stat_conflict !== 32'd5) $display("FAIL stats_conflict got %0d want 5", stat_conflict); else passed++;
   endtask
`endif

   initial begin
      tick();
      preload(10'd5, 32'hDEADBEEF);
      preload(10'd3, 32'hA5A50003);
      preload(10'd9, 32'h00000999);
      preload(10'd7, 32'h0);
      test_reset();
      test_fetch();
      test_priority();
      test_starve();
      test_reset_inflight();
      test_dm_during_fetch();
`ifdef ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
